// File: rtl/muldiv_unit_pkg.sv
// Shared instruction codes for the integer core: primary opcodes, SPECIAL
// function codes and the operation select of the HI/LO multiply/divide unit.
package muldiv_unit_pkg;

  localparam int unsigned CNT_W = 6;

  typedef enum logic [5:0] {
    OPC_SPECIAL = 6'h00,
    OPC_REGIMM  = 6'h01,
    OPC_J       = 6'h02,
    OPC_JAL     = 6'h03
  } opcode_t;

  typedef enum logic [5:0] {
    FN_MFHI  = 6'h10,
    FN_MTHI  = 6'h11,
    FN_MFLO  = 6'h12,
    FN_MTLO  = 6'h13,
    FN_MULT  = 6'h18,
    FN_MULTU = 6'h19,
    FN_DIV   = 6'h1a,
    FN_DIVU  = 6'h1b
  } func_t;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } muldiv_op_t;

endpackage

// File: rtl/muldiv_unit_divider.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per
// cycle for WIDTH cycles after start_i.
module muldiv_divider
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // done_o flags the edge that retires the final quotient bit, so the
  // owning FSM can leave its wait state on that same edge.
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = shifted - {1'b0, dvs_q};
    done_o   = active_q && (cnt_q == LAST);
    if (start_i) begin
      active_d = 1'b1;
      cnt_d    = '0;
      quo_d    = dividend_i;
      rem_d    = '0;
      dvs_d    = divisor_i;
    end else if (active_q) begin
      if (shifted >= {1'b0, dvs_q}) begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q + 1'b1;
      if (done_o) begin
        active_d = 1'b0;
        cnt_d    = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: pipelined behavioural multiplier, iterative
// signed/unsigned divider with sign fix-up, and MTHI/MTLO writes.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             read_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             stall_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_t;

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STAGES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, rs_q, rs_d;
  logic             done_q, done_d;
  logic             rs_neg_q, rs_neg_d, rt_neg_q, rt_neg_d;
  logic             dz_q, dz_d;
  logic [2*WIDTH-1:0] pipe_q [MUL_STAGES];
  logic [2*WIDTH-1:0] pipe_d [MUL_STAGES];

  muldiv_op_t       op;
  logic             is_mul, is_div, mul_load, div_start, rs_neg, rt_neg;
  logic [2*WIDTH-1:0] mul_a, mul_b, prod;
  logic [WIDTH-1:0] dvd_mag, dvs_mag, div_q, div_r, q_fix, r_fix;
  logic             div_done;

  assign op        = muldiv_op_t'(op_i);
  assign is_mul    = (op == MD_MULT) || (op == MD_MULTU);
  assign is_div    = (op == MD_DIV) || (op == MD_DIVU);
  assign mul_load  = (state_q == ST_IDLE) && start_i && is_mul;
  assign div_start = (state_q == ST_IDLE) && start_i && is_div && (rt_i != '0);
  assign rs_neg    = (op == MD_DIV) && rs_i[WIDTH-1];
  assign rt_neg    = (op == MD_DIV) && rt_i[WIDTH-1];
  assign dvd_mag   = rs_neg ? -rs_i : rs_i;
  assign dvs_mag   = rt_neg ? -rt_i : rt_i;

  // Sign-extending to 2*WIDTH lets one truncated multiply serve both MULT and MULTU.
  assign mul_a = {{WIDTH{(op == MD_MULT) & rs_i[WIDTH-1]}}, rs_i};
  assign mul_b = {{WIDTH{(op == MD_MULT) & rt_i[WIDTH-1]}}, rt_i};
  assign prod  = mul_a * mul_b;

  always_comb begin
    pipe_d[0] = mul_load ? prod : pipe_q[0];
    for (int unsigned i = 1; i < MUL_STAGES; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  muldiv_divider #(.WIDTH(WIDTH)) u_divider (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (div_start),
    .dividend_i  (dvd_mag),
    .divisor_i   (dvs_mag),
    .done_o      (div_done),
    .quotient_o  (div_q),
    .remainder_o (div_r)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    rs_d     = rs_q;
    rs_neg_d = rs_neg_q;
    rt_neg_d = rt_neg_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    q_fix    = rt_neg_q ^ rs_neg_q ? -div_q : div_q;
    r_fix    = rs_neg_q ? -div_r : div_r;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (is_mul) begin
            cnt_d   = '0;
            state_d = ST_MUL;
          end else if (is_div) begin
            rs_d     = rs_i;
            rs_neg_d = rs_neg;
            rt_neg_d = rt_neg;
            dz_d     = (rt_i == '0);
            state_d  = (rt_i == '0) ? ST_FIX : ST_DIV;
          end else if (op == MD_MTHI) begin
            hi_d   = rs_i;
            done_d = 1'b1;
          end else if (op == MD_MTLO) begin
            lo_d   = rs_i;
            done_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (cnt_q == MUL_LAST) begin
          {hi_d, lo_d} = pipe_q[MUL_STAGES-1];
          done_d       = 1'b1;
          cnt_d        = '0;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DIV: begin
        if (div_done) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (dz_q) begin
          lo_d = '1;
          hi_d = rs_q;
        end else begin
          lo_d = q_fix;
          hi_d = r_fix;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      rs_q     <= '0;
      rs_neg_q <= 1'b0;
      rt_neg_q <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      for (int unsigned i = 0; i < MUL_STAGES; i++) pipe_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      rs_q     <= rs_d;
      rs_neg_q <= rs_neg_d;
      rt_neg_q <= rt_neg_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
      for (int unsigned i = 0; i < MUL_STAGES; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign done_o  = done_q;
  assign busy_o  = (state_q != ST_IDLE);
  assign stall_o = read_i & busy_o;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a WIDTH=32/MUL_STAGES=1 instance and a
// WIDTH=16/MUL_STAGES=3 instance checked against hand-computed results.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_start = 1'b0, a_read = 1'b0;
  logic [2:0]  a_op = '0;
  logic [31:0] a_rs = '0, a_rt = '0, a_hi, a_lo;
  logic        a_busy, a_done, a_stall;

  logic        b_start = 1'b0, b_read = 1'b0;
  logic [2:0]  b_op = '0;
  logic [15:0] b_rs = '0, b_rt = '0, b_hi, b_lo;
  logic        b_busy, b_done, b_stall;

  int n_checks = 0;
  int n_fail   = 0;
  int lat, busy_n, stall_n;

  muldiv_unit #(.WIDTH(32), .MUL_STAGES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(a_start), .op_i(a_op), .rs_i(a_rs),
    .rt_i(a_rt), .read_i(a_read), .hi_o(a_hi), .lo_o(a_lo), .busy_o(a_busy),
    .done_o(a_done), .stall_o(a_stall)
  );

  muldiv_unit #(.WIDTH(16), .MUL_STAGES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(b_start), .op_i(b_op), .rs_i(b_rs),
    .rt_i(b_rt), .read_i(b_read), .hi_o(b_hi), .lo_o(b_lo), .busy_o(b_busy),
    .done_o(b_done), .stall_o(b_stall)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one op on dut_a; lat counts edges from the start edge until done_o
  // is seen. A second start (MTHI 0xDEAD) is driven at cycle inj_at if >= 0.
  task automatic run_a(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input int inj_at, output int l, output int bn, output int sn);
    a_op = op; a_rs = rs; a_rt = rt; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    l = 0; bn = 0; sn = 0;
    while (!a_done && l < 200) begin
      bn += int'(a_busy);
      sn += int'(a_stall);
      a_start = (l == inj_at);
      if (l == inj_at) begin
        a_op = MD_MTHI;
        a_rs = 32'h0000_DEAD;
      end
      @(posedge clk); #1;
      l++;
    end
    a_start = 1'b0;
    check("a_busy_in_done_cycle", 64'(a_busy), 64'd0);
  endtask

  task automatic run_b(input logic [2:0] op, input logic [15:0] rs, input logic [15:0] rt,
                       output int l);
    b_op = op; b_rs = rs; b_rt = rt; b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    l = 0;
    while (!b_done && l < 200) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  initial begin
    #12;
    check("rst_hi", 64'(a_hi), 64'd0);
    check("rst_lo", 64'(a_lo), 64'd0);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_done", 64'(a_done), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_a(MD_MULT, 32'hFFFF_FFFE, 32'd3, -1, lat, busy_n, stall_n);
    check("mult_lat", 64'(lat), 64'd1);
    check("mult_hi", 64'(a_hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(a_lo), 64'hFFFF_FFFA);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(a_done), 64'd0);

    run_a(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, lat, busy_n, stall_n);
    check("multu_hi", 64'(a_hi), 64'hFFFF_FFFE);
    check("multu_lo", 64'(a_lo), 64'h0000_0001);

    run_a(MD_DIV, 32'hFFFF_FFF9, 32'd2, -1, lat, busy_n, stall_n);
    check("div_lat", 64'(lat), 64'd33);
    check("div_busy_cycles", 64'(busy_n), 64'd33);
    check("div_lo", 64'(a_lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(a_hi), 64'hFFFF_FFFF);

    run_a(MD_DIVU, 32'd7, 32'd2, -1, lat, busy_n, stall_n);
    check("divu_lo", 64'(a_lo), 64'd3);
    check("divu_hi", 64'(a_hi), 64'd1);

    run_a(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat, busy_n, stall_n);
    check("divmin_lo", 64'(a_lo), 64'h8000_0000);
    check("divmin_hi", 64'(a_hi), 64'd0);

    run_a(MD_DIVU, 32'h0000_1234, 32'd0, -1, lat, busy_n, stall_n);
    check("dz_lat", 64'(lat), 64'd1);
    check("dz_lo", 64'(a_lo), 64'hFFFF_FFFF);
    check("dz_hi", 64'(a_hi), 64'h0000_1234);

    a_read = 1'b1;
    run_a(MD_DIVU, 32'd100, 32'd7, 5, lat, busy_n, stall_n);
    check("haz_stall_cycles", 64'(stall_n), 64'd33);
    check("haz_stall_done", 64'(a_stall), 64'd0);
    check("haz_lat", 64'(lat), 64'd33);
    check("haz_lo", 64'(a_lo), 64'd14);
    check("haz_hi", 64'(a_hi), 64'd2);
    a_read = 1'b0;

    run_a(MD_MTLO, 32'h55, 32'd0, -1, lat, busy_n, stall_n);
    check("mtlo_lat", 64'(lat), 64'd0);
    check("mtlo_lo", 64'(a_lo), 64'h55);
    check("mtlo_hi", 64'(a_hi), 64'd2);

    a_op = MD_DIV; a_rs = 32'd100; a_rt = 32'd7; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("abort_busy_before", 64'(a_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_hi", 64'(a_hi), 64'd0);
    check("abort_lo", 64'(a_lo), 64'd0);
    check("abort_busy", 64'(a_busy), 64'd0);
    check("abort_done", 64'(a_done), 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_a(MD_MULT, 32'd5, 32'd6, -1, lat, busy_n, stall_n);
    check("post_rst_lat", 64'(lat), 64'd1);
    check("post_rst_lo", 64'(a_lo), 64'd30);
    check("post_rst_hi", 64'(a_hi), 64'd0);

    run_b(MD_MULT, 16'd5, 16'd6, lat);
    check("b_mult_lat", 64'(lat), 64'd3);
    check("b_mult_lo", 64'(b_lo), 64'h001E);
    check("b_mult_hi", 64'(b_hi), 64'h0000);

    run_b(MD_DIV, 16'hFFF9, 16'd2, lat);
    check("b_div_lat", 64'(lat), 64'd17);
    check("b_div_lo", 64'(b_lo), 64'hFFFD);
    check("b_div_hi", 64'(b_hi), 64'hFFFF);

    run_b(MD_MULTU, 16'hFFFF, 16'hFFFF, lat);
    check("b_multu_hi", 64'(b_hi), 64'hFFFE);
    check("b_multu_lo", 64'(b_lo), 64'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
